pipeline_hazard_unit: RTL and testbench

Parametrised hazard controller for the 5-stage pipelined datapath; it replaces the hard-tied `PCWrite = 1`, `DecodeWrite = 1` and `controlMuxSignal = 1` of the current top level. It detects load-use and decode-stage branch hazards, drives stall, bubble and flush controls, and selects forwarding for the EX-stage ALU operands and the decode-stage branch comparator. It also keeps saturating stall and flush counters, plus a watchdog that flags any stall run longer than the pipeline can legally produce.

---
 rtl/pipeline_hazard_unit_if.sv | 51 +++++
 rtl/pipeline_hazard_unit.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if
//   Bundles every pipeline-side signal of the hazard controller.
//   slave  : the hazard unit (reads stage info, drives controls/forwarding/stats)
//   master : the datapath (drives stage info, consumes controls/forwarding/stats)
//   Decode : ID_Rs/ID_Rt/ID_UsesRs/ID_UsesRt/ID_IsBranch/ID_Redirect
//   EX     : EX_Rs/EX_Rt/EX_UsesRs/EX_UsesRt/EX_Rd/EX_RegWrite/EX_MemRead
//   MEM/WB : MEM_Rd/MEM_RegWrite/MEM_MemRead, WB_Rd/WB_RegWrite
//   Ctrl   : ClearCounters in; PCWrite/DecodeWrite/ControlMuxSignal/FlushDecode,
//            ForwardA/B, ForwardBrA/B, StallCount/FlushCount/StallRun/HazardError out
interface pipeline_hazard_unit_if #(
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 2
);
   localparam int unsigned RUN_W = $clog2(MAX_STALL + 2);

   logic [REG_AW-1:0] ID_Rs, ID_Rt;
   logic              ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_Redirect;
   logic [REG_AW-1:0] EX_Rs, EX_Rt, EX_Rd;
   logic              EX_UsesRs, EX_UsesRt, EX_RegWrite, EX_MemRead;
   logic [REG_AW-1:0] MEM_Rd;
   logic              MEM_RegWrite, MEM_MemRead;
   logic [REG_AW-1:0] WB_Rd;
   logic              WB_RegWrite;
   logic              ClearCounters;

   logic              PCWrite, DecodeWrite, ControlMuxSignal, FlushDecode;
   logic [1:0]        ForwardA, ForwardB;
   logic              ForwardBrA, ForwardBrB;
   logic [CNT_W-1:0]  StallCount, FlushCount;
   logic [RUN_W-1:0]  StallRun;
   logic              HazardError;

   modport slave (
      input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_Redirect,
      input  EX_Rs, EX_Rt, EX_Rd, EX_UsesRs, EX_UsesRt, EX_RegWrite, EX_MemRead,
      input  MEM_Rd, MEM_RegWrite, MEM_MemRead, WB_Rd, WB_RegWrite, ClearCounters,
      output PCWrite, DecodeWrite, ControlMuxSignal, FlushDecode,
      output ForwardA, ForwardB, ForwardBrA, ForwardBrB,
      output StallCount, FlushCount, StallRun, HazardError
   );

   modport master (
      output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_Redirect,
      output EX_Rs, EX_Rt, EX_Rd, EX_UsesRs, EX_UsesRt, EX_RegWrite, EX_MemRead,
      output MEM_Rd, MEM_RegWrite, MEM_MemRead, WB_Rd, WB_RegWrite, ClearCounters,
      input  PCWrite, DecodeWrite, ControlMuxSignal, FlushDecode,
      input  ForwardA, ForwardB, ForwardBrA, ForwardBrB,
      input  StallCount, FlushCount, StallRun, HazardError
   );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard controller for the 5-stage pipeline: load-use and decode-branch
//   stall detection, redirect flush, EX and branch-comparator forwarding,
//   saturating stall/flush counters and a stall-run watchdog.
//   Clk   : rising-edge clock
//   Reset : asynchronous active-high reset; also forces the pipeline controls
//           to their pass-through values while asserted
//   hz    : pipeline_hazard_unit_if.slave, all stage info in, controls out
module pipeline_hazard_unit #(
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 2
) (
   input  logic                   Clk,
   input  logic                   Reset,
   pipeline_hazard_unit_if.slave  hz
);
   localparam int unsigned RUN_W = $clog2(MAX_STALL + 2);
   localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);
   localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

   typedef enum logic [1:0] {WD_RUN, WD_STALLING, WD_ERROR} wd_state_e;

   // A producer feeds a source only for a non-zero, written, actually-read register.
   function automatic logic dest_match(input logic [REG_AW-1:0] rd, input logic wr,
                                       input logic [REG_AW-1:0] src, input logic used);
      return (rd != '0) && wr && used && (rd == src);
   endfunction

   logic ex_hits_id, mem_hits_id, load_use, br_haz, stall, flush;
   logic mem_fwd_a, wb_fwd_a, mem_fwd_b, wb_fwd_b;

   wd_state_e        wd_q, wd_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      ex_hits_id  = dest_match(hz.EX_Rd, hz.EX_RegWrite, hz.ID_Rs, hz.ID_UsesRs) |
                    dest_match(hz.EX_Rd, hz.EX_RegWrite, hz.ID_Rt, hz.ID_UsesRt);
      mem_hits_id = dest_match(hz.MEM_Rd, hz.MEM_RegWrite, hz.ID_Rs, hz.ID_UsesRs) |
                    dest_match(hz.MEM_Rd, hz.MEM_RegWrite, hz.ID_Rt, hz.ID_UsesRt);
      load_use    = hz.EX_MemRead & ex_hits_id;
      br_haz      = hz.ID_IsBranch & (ex_hits_id | (hz.MEM_MemRead & mem_hits_id));
      // Reset masks both so counters and controls see a quiet pipeline.
      stall       = ~Reset & (load_use | br_haz);
      flush       = ~Reset & hz.ID_Redirect & ~(load_use | br_haz);
      mem_fwd_a   = dest_match(hz.MEM_Rd, hz.MEM_RegWrite, hz.EX_Rs, hz.EX_UsesRs);
      wb_fwd_a    = dest_match(hz.WB_Rd,  hz.WB_RegWrite,  hz.EX_Rs, hz.EX_UsesRs);
      mem_fwd_b   = dest_match(hz.MEM_Rd, hz.MEM_RegWrite, hz.EX_Rt, hz.EX_UsesRt);
      wb_fwd_b    = dest_match(hz.WB_Rd,  hz.WB_RegWrite,  hz.EX_Rt, hz.EX_UsesRt);
   end

   // Stall run and counters: clear has priority over any increment.
   always_comb begin
      run_d       = '0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hz.ClearCounters) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall)
            run_d = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
         if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         run_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         run_q       <= run_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Watchdog state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) wd_q <= WD_RUN;
      else       wd_q <= wd_d;
   end

   // Watchdog next state: ERROR is sticky; a stall cycle entered with the run
   // already at the legal maximum means the run is about to exceed it.
   always_comb begin
      wd_d = wd_q;
      case (wd_q)
         WD_ERROR: wd_d = WD_ERROR;
         default: begin
            if (stall && (run_q == RUN_LIMIT)) wd_d = WD_ERROR;
            else if (run_d != '0)              wd_d = WD_STALLING;
            else                               wd_d = WD_RUN;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      hz.PCWrite          = ~stall;
      hz.DecodeWrite      = ~stall;
      hz.ControlMuxSignal = ~stall;
      hz.FlushDecode      = flush;
      hz.ForwardA         = '0;
      hz.ForwardB         = '0;
      hz.ForwardBrA       = 1'b0;
      hz.ForwardBrB       = 1'b0;
      if (!Reset) begin
         hz.ForwardA   = mem_fwd_a ? 2'b10 : (wb_fwd_a ? 2'b01 : 2'b00);
         hz.ForwardB   = mem_fwd_b ? 2'b10 : (wb_fwd_b ? 2'b01 : 2'b00);
         hz.ForwardBrA = hz.ID_IsBranch & ~hz.MEM_MemRead &
                         dest_match(hz.MEM_Rd, hz.MEM_RegWrite, hz.ID_Rs, hz.ID_UsesRs);
         hz.ForwardBrB = hz.ID_IsBranch & ~hz.MEM_MemRead &
                         dest_match(hz.MEM_Rd, hz.MEM_RegWrite, hz.ID_Rt, hz.ID_UsesRt);
      end
      hz.StallCount  = stall_cnt_q;
      hz.FlushCount  = flush_cnt_q;
      hz.StallRun    = run_q;
      hz.HazardError = (wd_q == WD_ERROR);
   end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit
//   Directed scenarios with literal expectations, then randomized traffic
//   checked every cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_unit;
   localparam int AW   = 5;
   localparam int CW   = 2;
   localparam int MS   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   pipeline_hazard_unit_if #(.REG_AW(AW), .CNT_W(CW), .MAX_STALL(MS)) hif();
   pipeline_hazard_unit #(.REG_AW(AW), .CNT_W(CW), .MAX_STALL(MS)) dut (
      .Clk(Clk), .Reset(Reset), .hz(hif)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_run = 0, m_scnt = 0, m_fcnt = 0, m_err = 0;

   function automatic bit feeds(input int rd, input bit wr, input int src, input bit used);
      return rd != 0 && wr && used && rd == src;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic bit id_needs(input int rd, input bit wr);
      return feeds(rd, wr, int'(hif.ID_Rs), hif.ID_UsesRs) ||
             feeds(rd, wr, int'(hif.ID_Rt), hif.ID_UsesRt);
   endfunction

   function automatic bit model_stall();
      bit lu, bh;
      lu = hif.EX_MemRead && id_needs(int'(hif.EX_Rd), hif.EX_RegWrite);
      bh = hif.ID_IsBranch && (id_needs(int'(hif.EX_Rd), hif.EX_RegWrite) ||
           (hif.MEM_MemRead && id_needs(int'(hif.MEM_Rd), hif.MEM_RegWrite)));
      return lu || bh;
   endfunction

   function automatic int fwd_sel(input int src, input bit used);
      if (feeds(int'(hif.MEM_Rd), hif.MEM_RegWrite, src, used)) return 2;
      if (feeds(int'(hif.WB_Rd), hif.WB_RegWrite, src, used))   return 1;
      return 0;
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_run <= 0; m_scnt <= 0; m_fcnt <= 0; m_err <= 0;
      end else begin
         if (model_stall() && m_run == MS) m_err <= 1;
         m_run  <= hif.ClearCounters ? 0 : (model_stall() ? sat(m_run + 1, MS + 1) : 0);
         m_scnt <= hif.ClearCounters ? 0 : sat(m_scnt + int'(model_stall()), CMAX);
         m_fcnt <= hif.ClearCounters ? 0 :
                   sat(m_fcnt + int'(hif.ID_Redirect && !model_stall()), CMAX);
      end
   end

   always @(negedge Clk) begin
      bit st, brA, brB;
      st  = !Reset && model_stall();
      brA = !Reset && hif.ID_IsBranch && !hif.MEM_MemRead &&
            feeds(int'(hif.MEM_Rd), hif.MEM_RegWrite, int'(hif.ID_Rs), hif.ID_UsesRs);
      brB = !Reset && hif.ID_IsBranch && !hif.MEM_MemRead &&
            feeds(int'(hif.MEM_Rd), hif.MEM_RegWrite, int'(hif.ID_Rt), hif.ID_UsesRt);
      check("m_PCWrite",     int'(hif.PCWrite),          int'(!st));
      check("m_DecodeWrite", int'(hif.DecodeWrite),      int'(!st));
      check("m_CtrlMux",     int'(hif.ControlMuxSignal), int'(!st));
      check("m_Flush",       int'(hif.FlushDecode),      int'(!Reset && hif.ID_Redirect && !st));
      check("m_ForwardA",    int'(hif.ForwardA),
            Reset ? 0 : fwd_sel(int'(hif.EX_Rs), hif.EX_UsesRs));
      check("m_ForwardB",    int'(hif.ForwardB),
            Reset ? 0 : fwd_sel(int'(hif.EX_Rt), hif.EX_UsesRt));
      check("m_ForwardBrA",  int'(hif.ForwardBrA),       int'(brA));
      check("m_ForwardBrB",  int'(hif.ForwardBrB),       int'(brB));
      check("m_StallCount",  int'(hif.StallCount),       m_scnt);
      check("m_FlushCount",  int'(hif.FlushCount),       m_fcnt);
      check("m_StallRun",    int'(hif.StallRun),         m_run);
      check("m_HazardError", int'(hif.HazardError),      m_err);
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      hif.ID_Rs = '0; hif.ID_Rt = '0; hif.ID_UsesRs = 0; hif.ID_UsesRt = 0;
      hif.ID_IsBranch = 0; hif.ID_Redirect = 0;
      hif.EX_Rs = '0; hif.EX_Rt = '0; hif.EX_Rd = '0; hif.EX_UsesRs = 0; hif.EX_UsesRt = 0;
      hif.EX_RegWrite = 0; hif.EX_MemRead = 0;
      hif.MEM_Rd = '0; hif.MEM_RegWrite = 0; hif.MEM_MemRead = 0;
      hif.WB_Rd = '0; hif.WB_RegWrite = 0; hif.ClearCounters = 0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      Reset = 1'b1;
      idle();
      tick();
      Reset = 1'b0;
   endtask

   task automatic ex_load(input int rd);
      hif.EX_Rd = AW'(rd); hif.EX_RegWrite = 1; hif.EX_MemRead = 1;
   endtask

   task automatic id_reads_rs(input int rs);
      hif.ID_Rs = AW'(rs); hif.ID_UsesRs = 1;
   endtask

   initial begin
      idle();
      Reset = 1'b1;
      tick(); tick();
      #1;
      check("rst_PCWrite",    int'(hif.PCWrite), 1);
      check("rst_StallCount", int'(hif.StallCount), 0);
      check("rst_HazardErr",  int'(hif.HazardError), 0);
      check("rst_StallRun",   int'(hif.StallRun), 0);
      tick();
      Reset = 1'b0;

      // load-use: lw $8 in EX, add $8 in ID
      do_reset();
      ex_load(8); id_reads_rs(8);
      #1;
      check("lu_PCWrite", int'(hif.PCWrite), 0);
      check("lu_CtrlMux", int'(hif.ControlMuxSignal), 0);
      check("lu_DecWr",   int'(hif.DecodeWrite), 0);
      tick();
      hif.EX_Rd = '0; hif.EX_RegWrite = 0; hif.EX_MemRead = 0;
      hif.MEM_Rd = 8; hif.MEM_RegWrite = 1; hif.MEM_MemRead = 1;
      #1;
      check("lu_release_PCWrite", int'(hif.PCWrite), 1);
      check("lu_StallCount",      int'(hif.StallCount), 1);
      check("lu_StallRun",        int'(hif.StallRun), 1);
      tick();
      hif.ID_Rs = '0; hif.ID_UsesRs = 0;
      hif.EX_Rs = 8; hif.EX_UsesRs = 1;
      hif.MEM_Rd = '0; hif.MEM_RegWrite = 0; hif.MEM_MemRead = 0;
      hif.WB_Rd = 8; hif.WB_RegWrite = 1;
      #1;
      check("lu_ForwardA",     int'(hif.ForwardA), 1);
      check("lu_StallRun_end", int'(hif.StallRun), 0);

      // branch on a load result
      do_reset();
      ex_load(8); id_reads_rs(8); hif.ID_IsBranch = 1;
      #1;
      check("bl_stall1", int'(hif.PCWrite), 0);
      tick();
      hif.EX_Rd = '0; hif.EX_RegWrite = 0; hif.EX_MemRead = 0;
      hif.MEM_Rd = 8; hif.MEM_RegWrite = 1; hif.MEM_MemRead = 1;
      #1;
      check("bl_stall2",    int'(hif.PCWrite), 0);
      check("bl_run1",      int'(hif.StallRun), 1);
      check("bl_noBrFwd",   int'(hif.ForwardBrA), 0);
      tick();
      hif.MEM_Rd = '0; hif.MEM_RegWrite = 0; hif.MEM_MemRead = 0;
      hif.WB_Rd = 8; hif.WB_RegWrite = 1;
      #1;
      check("bl_go",        int'(hif.PCWrite), 1);
      check("bl_run2",      int'(hif.StallRun), 2);
      check("bl_noErr",     int'(hif.HazardError), 0);
      check("bl_StallCnt",  int'(hif.StallCount), 2);

      // forward priority and zero register
      do_reset();
      hif.MEM_Rd = 5; hif.MEM_RegWrite = 1; hif.WB_Rd = 5; hif.WB_RegWrite = 1;
      hif.EX_Rs = 5; hif.EX_UsesRs = 1; hif.EX_Rt = 5; hif.EX_UsesRt = 1;
      #1;
      check("fp_ForwardA_mem", int'(hif.ForwardA), 2);
      check("fp_ForwardB_mem", int'(hif.ForwardB), 2);
      hif.MEM_RegWrite = 0;
      #1;
      check("fp_ForwardA_wb", int'(hif.ForwardA), 1);
      hif.MEM_RegWrite = 1; hif.MEM_Rd = '0; hif.WB_Rd = '0; hif.EX_Rs = '0;
      #1;
      check("fp_ForwardA_r0", int'(hif.ForwardA), 0);
      idle();
      hif.ID_IsBranch = 1; hif.ID_Rt = 6; hif.ID_UsesRt = 1;
      hif.MEM_Rd = 6; hif.MEM_RegWrite = 1;
      #1;
      check("fp_ForwardBrB", int'(hif.ForwardBrB), 1);
      check("fp_BrNoStall",  int'(hif.PCWrite), 1);

      // redirect flush, then redirect during a stall
      do_reset();
      hif.ID_Redirect = 1;
      #1;
      check("rd_Flush", int'(hif.FlushDecode), 1);
      tick();
      hif.ID_Redirect = 0;
      #1;
      check("rd_FlushCount", int'(hif.FlushCount), 1);
      check("rd_FlushOff",   int'(hif.FlushDecode), 0);
      hif.ID_Redirect = 1; ex_load(9); id_reads_rs(9);
      #1;
      check("rd_StallFlush", int'(hif.FlushDecode), 0);
      tick();
      idle();
      #1;
      check("rd_FlushCount2", int'(hif.FlushCount), 1);

      // watchdog
      do_reset();
      ex_load(8); id_reads_rs(8);
      tick(); #1;
      check("wd_run1", int'(hif.StallRun), 1);
      tick(); #1;
      check("wd_err_at2", int'(hif.HazardError), 0);
      tick(); #1;
      check("wd_err_at3", int'(hif.HazardError), 1);
      check("wd_run3",    int'(hif.StallRun), 3);
      idle();
      hif.ClearCounters = 1;
      tick();
      hif.ClearCounters = 0;
      #1;
      check("wd_clr_err",   int'(hif.HazardError), 1);
      check("wd_clr_count", int'(hif.StallCount), 0);
      Reset = 1'b1;
      #1;
      check("wd_rst_err", int'(hif.HazardError), 0);
      tick();
      Reset = 1'b0;

      // saturation, clear-vs-increment, reset mid-stall
      do_reset();
      ex_load(8); id_reads_rs(8);
      repeat (5) tick();
      #1;
      check("sat_StallCount", int'(hif.StallCount), 3);
      hif.ClearCounters = 1;
      tick();
      hif.ClearCounters = 0;
      #1;
      check("sat_clr_win", int'(hif.StallCount), 0);
      check("sat_clr_run", int'(hif.StallRun), 0);
      Reset = 1'b1;
      #1;
      check("sat_rst_PCWrite", int'(hif.PCWrite), 1);
      check("sat_rst_CtrlMux", int'(hif.ControlMuxSignal), 1);
      tick();
      Reset = 1'b0;
      idle();

      // randomized traffic; small register range for frequent matches,
      // occasional held inputs to build longer stall runs
      for (int n = 0; n < 3000; n++) begin
         tick();
         Reset = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 3) != 0) begin
            hif.ID_Rs = AW'($urandom_range(0, 3)); hif.ID_Rt = AW'($urandom_range(0, 3));
            hif.ID_UsesRs = 1'($urandom_range(0, 1)); hif.ID_UsesRt = 1'($urandom_range(0, 1));
            hif.ID_IsBranch = 1'($urandom_range(0, 1)); hif.ID_Redirect = 1'($urandom_range(0, 1));
            hif.EX_Rs = AW'($urandom_range(0, 3)); hif.EX_Rt = AW'($urandom_range(0, 3));
            hif.EX_Rd = AW'($urandom_range(0, 3));
            hif.EX_UsesRs = 1'($urandom_range(0, 1)); hif.EX_UsesRt = 1'($urandom_range(0, 1));
            hif.EX_RegWrite = 1'($urandom_range(0, 1)); hif.EX_MemRead = 1'($urandom_range(0, 1));
            hif.MEM_Rd = AW'($urandom_range(0, 3));
            hif.MEM_RegWrite = 1'($urandom_range(0, 1)); hif.MEM_MemRead = 1'($urandom_range(0, 1));
            hif.WB_Rd = AW'($urandom_range(0, 3)); hif.WB_RegWrite = 1'($urandom_range(0, 1));
         end
         hif.ClearCounters = ($urandom_range(0, 15) == 0);
      end
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
